// File: rtl/erm16_pkg.sv
// ERM16 decode definitions: instruction field positions, opcode classes, decode helpers.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package erm16_pkg;

    localparam int BITS    = 16;
    localparam int REG_W   = 3;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 6;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_I_FIRST = 4'b1000;
    localparam logic [OP_W-1:0] OP_I_LAST  = 4'b1011;
    localparam logic [OP_W-1:0] OP_BRANCH  = 4'b1100;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_I,
        CLS_BR,
        CLS_NONE
    } cls_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } fields_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic             wr;
    } meta_t;

    function automatic cls_e op_class(input logic [OP_W-1:0] op);
        if (!op[OP_W-1])                           return CLS_R;
        else if (op >= OP_I_FIRST && op <= OP_I_LAST) return CLS_I;
        else if (op == OP_BRANCH)                  return CLS_BR;
        else                                       return CLS_NONE;
    endfunction

    function automatic logic reads_rs1(input logic [OP_W-1:0] op);
        return op_class(op) != CLS_NONE;
    endfunction

    function automatic logic reads_rs2(input logic [OP_W-1:0] op);
        return op_class(op) == CLS_R || op_class(op) == CLS_BR;
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return op_class(op) == CLS_R || op_class(op) == CLS_I;
    endfunction

    // rs2 and imm6 overlap on purpose; the class decides which one is meaningful.
    function automatic fields_t split(input logic [BITS-1:0] instr);
        fields_t f;
        f.op  = instr[OP_LSB  +: OP_W];
        f.rd  = instr[RD_LSB  +: REG_W];
        f.rs1 = instr[RS1_LSB +: REG_W];
        f.rs2 = instr[RS2_LSB +: REG_W];
        f.imm = instr[IMM_LSB +: IMM_W];
        return f;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// In-flight destination tracker with RAW/WAW hazard query.
// Latency: set/clear take effect on the next edge; the hazard query is combinational.
// Backpressure: none itself; the hazard output is what stalls the decode stage.
module scoreboard #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_en,
    input  logic [N-1:0] set_addr,
    input  logic         clr_en,
    input  logic [N-1:0] clr_addr,
    input  logic         fclr_en,
    input  logic [N-1:0] fclr_addr,
    input  logic [N-1:0] rs1,
    input  logic         rs1_en,
    input  logic [N-1:0] rs2,
    input  logic         rs2_en,
    input  logic [N-1:0] rd,
    input  logic         rd_en,
    output logic         hazard
);

    logic [2**N-1:0] busy;
    logic [2**N-1:0] busy_nxt;
    logic            hit1;
    logic            hit2;
    logic            hitd;

    // Clears are applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)  busy_nxt[clr_addr]  = 1'b0;
        if (fclr_en) busy_nxt[fclr_addr] = 1'b0;
        if (set_en)  busy_nxt[set_addr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

    // A register being written back this cycle is no longer a hazard: forwarding covers it.
    assign hit1 = busy[rs1] & ~(clr_en & (clr_addr == rs1));
    assign hit2 = busy[rs2] & ~(clr_en & (clr_addr == rs2));
    assign hitd = busy[rd]  & ~(clr_en & (clr_addr == rd));

    assign hazard = (rs1_en & hit1) | (rs2_en & hit2) | (rd_en & hitd);

endmodule

// File: rtl/operand_fetch.sv
// ERM16 decode/operand fetch: field split, regfile addressing, write-back forwarding, hazard stall.
// Latency: 1 cycle from accept to out_*; one instruction per cycle when hazard-free.
// Backpressure: in_ready drops on hazard, flush, reset, or a held output with out_ready low.
module operand_fetch
    import erm16_pkg::*;
#(
    parameter int bits = BITS,
    parameter int N    = REG_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [bits-1:0] in_instr,
    output logic            in_ready,
    input  logic            flush,
    output logic [N-1:0]    RA1,
    output logic [N-1:0]    RA2,
    input  logic [bits-1:0] RD1,
    input  logic [bits-1:0] RD2,
    input  logic            wb_we,
    input  logic [N-1:0]    wb_addr,
    input  logic [bits-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [N-1:0]    out_rd,
    output logic            out_wr,
    output logic [bits-1:0] out_a,
    output logic [bits-1:0] out_b
);

    fields_t         f;
    logic            rd_rs1;
    logic            rd_rs2;
    logic            wr_rd;
    logic            hazard;
    logic            accept;
    logic [bits-1:0] fwd_a;
    logic [bits-1:0] fwd_b;
    logic [bits-1:0] imm_ext;
    logic [bits-1:0] opa;
    logic [bits-1:0] opb;
    meta_t           meta_q;
    logic [bits-1:0] a_q;
    logic [bits-1:0] b_q;

    assign f      = split(in_instr);
    assign rd_rs1 = reads_rs1(f.op);
    assign rd_rs2 = reads_rs2(f.op);
    assign wr_rd  = writes_rd(f.op);

    assign RA1 = f.rs1;
    assign RA2 = f.rs2;

    // The regfile write lands at the end of this cycle, so bypass it for same-cycle readers.
    assign fwd_a   = (wb_we && wb_addr == f.rs1) ? wb_data : RD1;
    assign fwd_b   = (wb_we && wb_addr == f.rs2) ? wb_data : RD2;
    assign imm_ext = {{(bits-IMM_W){f.imm[IMM_W-1]}}, f.imm};

    always_comb begin
        opa = '0;
        opb = '0;
        case (op_class(f.op))
            CLS_R, CLS_BR: begin
                opa = fwd_a;
                opb = fwd_b;
            end
            CLS_I: begin
                opa = fwd_a;
                opb = imm_ext;
            end
            default: ;
        endcase
    end

    scoreboard #(.N(N)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (accept & wr_rd),
        .set_addr  (f.rd),
        .clr_en    (wb_we),
        .clr_addr  (wb_addr),
        .fclr_en   (flush & out_valid & out_wr),
        .fclr_addr (out_rd),
        .rs1       (f.rs1),
        .rs1_en    (rd_rs1),
        .rs2       (f.rs2),
        .rs2_en    (rd_rs2),
        .rd        (f.rd),
        .rd_en     (wr_rd),
        .hazard    (hazard)
    );

    assign in_ready = rst & ~(in_valid & hazard) & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            meta_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            meta_q    <= '{op: f.op, rd: f.rd, wr: wr_rd};
            a_q       <= opa;
            b_q       <= opb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op = meta_q.op;
    assign out_rd = meta_q.rd;
    assign out_wr = meta_q.wr;
    assign out_a  = a_q;
    assign out_b  = b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random checks of operand_fetch against an instruction-level reference model.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [2:0]  RA1;
    logic [2:0]  RA2;
    logic [15:0] RD1;
    logic [15:0] RD2;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic [15:0] out_a;
    logic [15:0] out_b;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .RA1       (RA1),
        .RA2       (RA2),
        .RD1       (RD1),
        .RD2       (RD2),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file stand-in driven by the DUT's read addresses.
    logic [15:0] regs [8];
    assign RD1 = regs[RA1];
    assign RD2 = regs[RA2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0]  m_busy  = '0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_op    = '0;
    logic [2:0]  m_rd    = '0;
    logic        m_wr    = 1'b0;
    logic [15:0] m_a     = '0;
    logic [15:0] m_b     = '0;
    logic        seen_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the model, check registers.
    task automatic step(input logic v, input logic [15:0] ins, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic ordy, input logic fl, input logic r);
        int          op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] opnd1, opnd2, sx;
        logic        uses1, uses2, wr, stall, exp_rdy, acc;
        logic [7:0]  n_busy;
        logic        n_valid;
        in_valid = v; in_instr = ins; wb_we = we; wb_addr = wa; wb_data = wd;
        out_ready = ordy; flush = fl; rst = r;
        #3;
        op  = int'(ins[15:12]);
        rd  = ins[11:9];
        rs1 = ins[8:6];
        rs2 = ins[5:3];
        sx  = {{10{ins[5]}}, ins[5:0]};
        uses1 = (op <= 12);
        uses2 = (op < 8) || (op == 12);
        wr    = (op <= 11);
        opnd1 = (we && wa == rs1) ? wd : regs[rs1];
        opnd2 = (we && wa == rs2) ? wd : regs[rs2];
        stall = v && ((uses1 && m_busy[rs1] && !(we && wa == rs1)) ||
                      (uses2 && m_busy[rs2] && !(we && wa == rs2)) ||
                      (wr    && m_busy[rd]  && !(we && wa == rd)));
        exp_rdy = r && !stall && !fl && (!m_valid || ordy);
        acc = v && exp_rdy;
        seen_rdy = in_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("RA1", {29'b0, RA1}, {29'b0, rs1});
        chk("RA2", {29'b0, RA2}, {29'b0, rs2});

        n_busy  = m_busy;
        n_valid = m_valid;
        if (we) n_busy[wa] = 1'b0;
        if (fl && m_valid && m_wr) n_busy[m_rd] = 1'b0;
        if (acc && wr) n_busy[rd] = 1'b1;
        if (fl) n_valid = 1'b0;
        else if (acc) n_valid = 1'b1;
        else if (ordy) n_valid = 1'b0;

        @(posedge clk);
        #1;
        if (!r) begin
            m_busy = '0; m_valid = 1'b0; m_op = '0; m_rd = '0; m_wr = 1'b0; m_a = '0; m_b = '0;
        end else begin
            m_busy  = n_busy;
            m_valid = n_valid;
            if (acc) begin
                m_op = ins[15:12];
                m_rd = rd;
                m_wr = wr;
                m_a  = uses1 ? opnd1 : 16'h0;
                m_b  = uses2 ? opnd2 : ((op >= 8 && op <= 11) ? sx : 16'h0);
            end
        end
        if (we) regs[wa] = wd;

        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_op",    {28'b0, out_op},    {28'b0, m_op});
        chk("out_rd",    {29'b0, out_rd},    {29'b0, m_rd});
        chk("out_wr",    {31'b0, out_wr},    {31'b0, m_wr});
        chk("out_a",     {16'b0, out_a},     {16'b0, m_a});
        chk("out_b",     {16'b0, out_b},     {16'b0, m_b});
        chk("busy",      {24'b0, dut.u_sb.busy}, {24'b0, m_busy});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset: in_ready held low even with a valid instruction offered.
        step(1, 16'h1248, 0, 0, 0, 1, 0, 0);
        chk("reset_in_ready", {31'b0, seen_rdy}, 32'd0);
        step(0, 16'h0000, 0, 0, 0, 1, 0, 0);

        // Independent R-type stream.
        step(1, 16'h1248, 0, 0, 0, 1, 0, 1);
        chk("rtype_op", {28'b0, out_op}, 32'd1);
        step(1, 16'h2690, 0, 0, 0, 1, 0, 1);
        chk("rtype_valid", {31'b0, out_valid}, 32'd1);
        step(0, 16'h0000, 1, 1, 16'h1111, 1, 0, 1);
        step(0, 16'h0000, 1, 3, 16'h3333, 1, 0, 1);

        // I-type with negative imm6.
        step(1, 16'h883E, 0, 0, 0, 1, 0, 1);
        chk("imm_sext", {16'b0, out_b}, 32'h0000FFFE);
        step(0, 16'h0000, 1, 4, 16'h4444, 1, 0, 1);

        // RAW on r3, released by a same-cycle write-back.
        step(1, 16'h1600, 0, 0, 0, 1, 0, 1);
        step(1, 16'h2CC0, 0, 0, 0, 1, 0, 1);
        chk("raw_stall", {31'b0, seen_rdy}, 32'd0);
        step(1, 16'h2CC0, 0, 0, 0, 1, 0, 1);
        step(1, 16'h2CC0, 1, 3, 16'hBEEF, 1, 0, 1);
        chk("raw_fwd_ready", {31'b0, seen_rdy}, 32'd1);
        chk("raw_fwd_a", {16'b0, out_a}, 32'h0000BEEF);
        step(0, 16'h0000, 1, 6, 16'h6666, 1, 0, 1);

        // Set and clear of r5 in one cycle: set wins.
        step(1, 16'h1A00, 0, 0, 0, 1, 0, 1);
        step(1, 16'h1A00, 1, 5, 16'h5555, 1, 0, 1);
        chk("set_wins", {31'b0, dut.u_sb.busy[5]}, 32'd1);
        step(1, 16'h2F40, 0, 0, 0, 1, 0, 1);
        chk("r5_stall", {31'b0, seen_rdy}, 32'd0);
        step(1, 16'h2F40, 1, 5, 16'h1234, 1, 0, 1);
        chk("r5_a", {16'b0, out_a}, 32'h00001234);

        // Hold under backpressure, then flush.
        step(1, 16'h1400, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'hD000, 0, 0, 0, 0, 0, 1);
            chk("hold_ready", {31'b0, seen_rdy}, 32'd0);
            chk("hold_rd", {29'b0, out_rd}, 32'd2);
        end
        step(1, 16'hD000, 0, 0, 0, 0, 1, 1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_busy2", {31'b0, dut.u_sb.busy[2]}, 32'd0);

        // Reset mid-stream with busy = 8'h24.
        for (int i = 0; i < 8; i++) step(0, 16'h0000, 1, 3'(i), 16'(i * 16'h0101), 1, 0, 1);
        step(1, 16'h1400, 0, 0, 0, 1, 0, 1);
        step(1, 16'h1A00, 0, 0, 0, 1, 0, 1);
        chk("pre_rst_busy", {24'b0, dut.u_sb.busy}, 32'h24);
        step(0, 16'h0000, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {24'b0, dut.u_sb.busy}, 32'd0);
        chk("rst_a", {16'b0, out_a}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage of the ERM16 pipeline, sitting directly upstream of the 8×16 register file and downstream of instruction fetch. It splits each 16-bit instruction into register fields, drives the register file read addresses, and forwards same-cycle write-back data. It tracks in-flight destination registers in an 8-bit scoreboard, stalls on RAW/WAW hazards, and registers the decoded operands toward execute over a valid/ready handshake.

## Interface
- `bits`, 16: data and instruction width.
- `N`, 3: register address width (2**N registers).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`==0 resets on the `clk` edge).
- `in_valid` in 1, `in_instr` in bits, `in_ready` out 1: instruction from fetch.
- `flush` in 1: discard the held output instruction.
- `RA1`, `RA2` out N: register file read addresses (combinational from `in_instr`).
- `RD1`, `RD2` in bits: register file read data (combinational).
- `wb_we` in 1, `wb_addr` in N, `wb_data` in bits: write-back port, the same signals that drive `WE3/WA3/WD3`.
- `out_valid` out 1, `out_ready` in 1: handshake toward execute.
- `out_op` out 4, `out_rd` out N, `out_wr` out 1: opcode, destination, writes-rd flag.
- `out_a`, `out_b` out bits: operand A (rs1) and operand B (rs2 value or sign-extended imm6).

## Operation
- Field layout: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0].
- Classes:
  - op[3]==0: R-type; reads rs1 and rs2, writes rd.
  - 4'b1000–4'b1011: I-type; reads rs1, B=sext(imm6), writes rd.
  - 4'b1100: branch; reads rs1 and rs2, no write.
  - 4'b1101–4'b1111: no reads, no write; A=B=0.
- `RA1`=rs1 and `RA2`=rs2 always, regardless of class.
- Forwarding: if `wb_we` and `wb_addr`==RAx, the operand takes `wb_data`, otherwise `RDx`. Reads of r0 are not special.
- Scoreboard `busy[2**N]`:
  - Set bit rd when an instruction with `out_wr`=1 is accepted (in_valid&in_ready).
  - Clear bit `wb_addr` when `wb_we`.
  - On the same register in the same cycle, set wins over clear.
- Hazards: src_hit(r) = busy[r] & !(wb_we & wb_addr==r).
  - `stall` = in_valid & ((reads rs1 & src_hit(rs1)) | (reads rs2 & src_hit(rs2)) | (writes & busy[rd] & !(wb_we & wb_addr==rd))).
- `in_ready` = !stall & !flush & (!out_valid | out_ready).
- Output register: loads on accept; `out_valid` clears when out_ready & !accept.
- Flush: `out_valid`←0. If the held instruction had `out_wr`, its busy bit clears unless a write-back sets/clears it the same cycle (clear either way). No accept occurs in a flush cycle.
- Reset: `busy`=0, `out_valid`=0, `out_op/rd/wr/a/b`=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears at `out_*` after edge k. Throughput is 1 per cycle with no hazards.
- `out_*` hold stable while out_valid & !out_ready.
- A write-back in cycle k unblocks a dependent instruction in the same cycle k, through forwarding.
- `rst` low mid-stream: the next edge drops the held instruction and all busy bits. `in_ready`=0 while `rst`=0.

## Structure
- `erm16_pkg`: opcode localparams/enum, class decode functions (reads_rs1, reads_rs2, writes_rd), and field slice constants.
- One sub-module, `scoreboard`: busy vector with set/clear/flush-clear ports and the hazard query.

## Test plan
- Independent R-type stream (`0x1248`, `0x2690`) with out_ready=1 -> one output per cycle, 1-cycle latency, A/B equal to the regfile values.
- I-type imm6=6'b111110 -> out_b=16'hFFFE.
- Producer to rd=r3, then consumer reading r3 -> consumer stalls (`in_ready`=0) until `wb_we`,`wb_addr`=3,`wb_data`=16'hBEEF. It is accepted that cycle with out_a=16'hBEEF.
- Set and clear of r5 in the same cycle -> busy[5] stays 1. A later r5 reader stalls until the next r5 write-back.
- out_ready=0 for 3 cycles -> outputs held, `in_ready`=0. Then flush -> out_valid=0 and the rd busy bit cleared.
- `rst`=0 with out_valid=1 and busy=8'h24 -> after the edge, out_valid=0, busy=0, outputs 0.
